// File: rtl/gb_host_master.sv
// gb_host_master: converts a valid/ready command stream into single-cycle
// ghostbus write/read strobes and returns one response per beat on a
// valid/ready response stream. Reads honour the fixed READ_DELAY latency.
//
// Optional build macro GB_HOST_MASTER_BURST_EN: cmd_len=N issues N+1 beats
// of the same type at incrementing (wrapping) addresses. Without it cmd_len
// is ignored and every command is a single beat.
//
// Handshake rule (both streams): a transfer happens on a rising gb_clk edge
// where valid && ready are both high; once valid is raised, the payload is
// held stable until that edge, and ready may not depend on the same-cycle
// payload.
//
// dbg_state exposes the FSM state encoding (0=IDLE 1=WRITE 2=READ 3=WAIT
// 4=RESP) for external checkers.

module gb_host_master #(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int READ_DELAY = 3
) (
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [7:0]    cmd_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  generate
    if (READ_DELAY < 1) begin : g_bad_delay
      $error("gb_host_master: READ_DELAY must be >= 1");
    end
  endgenerate

  localparam int CW = $clog2(READ_DELAY + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q;
  logic [DW-1:0] rdata_q;
  logic [CW-1:0] cnt_q;
  logic          cmd_ready_q;
  logic          accept;
  logic          rsp_hs;
  logic          last_beat;

  assign accept = cmd_valid && cmd_ready_q;
  assign rsp_hs = (state == S_RESP) && rsp_ready;

`ifdef GB_HOST_MASTER_BURST_EN
  logic [7:0] beats_q;
  assign last_beat = (beats_q == 8'd0);
`else
  logic unused_cmd_len;
  assign unused_cmd_len = ^cmd_len;
  assign last_beat      = 1'b1;
`endif

  // State register
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = cmd_write ? S_WRITE : S_READ;
      S_WRITE: state_nxt = S_RESP;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_hs) begin
          if (last_beat) state_nxt = S_IDLE;
          else           state_nxt = wr_q ? S_WRITE : S_READ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    gb_wen    = (state == S_WRITE);
    gb_rstb   = (state == S_READ);
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

  // cmd_ready is registered so it is low out of reset and rises the cycle
  // after the FSM settles back into IDLE
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) cmd_ready_q <= 1'b0;
    else           cmd_ready_q <= (state_nxt == S_IDLE);
  end

  // Command latch, read-latency counter and response data capture
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef GB_HOST_MASTER_BURST_EN
      beats_q <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_write ? cmd_wdata : '0;
            wr_q    <= cmd_write;
`ifdef GB_HOST_MASTER_BURST_EN
            beats_q <= cmd_len;
`endif
          end
        end
        S_WRITE: rdata_q <= '0;
        // Strobe cycle is cycle 0; WAIT cycles 1..READ_DELAY count down to 0
        S_READ:  cnt_q <= CW'(READ_DELAY - 1);
        S_WAIT: begin
          if (cnt_q == '0) rdata_q <= gb_rdata;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_RESP: begin
          // Address advances only after the handshake so the response
          // fields stay stable while stalled
          if (rsp_hs && !last_beat) begin
            addr_q <= addr_q + AW'(1);
`ifdef GB_HOST_MASTER_BURST_EN
            beats_q <= beats_q - 8'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign gb_addr   = addr_q;
  assign gb_wdata  = wdata_q;
  assign rsp_write = wr_q;
  assign rsp_addr  = addr_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_gb_host_master.sv
// Directed bench for gb_host_master (default READ_DELAY=3). Covers reset,
// write, read at exact/early/late slave timing, response stall, reset during
// WAIT and the burst option (expectations follow GB_HOST_MASTER_BURST_EN).

module tb_gb_host_master;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RD = 3;
  localparam logic [DW-1:0] GARBAGE = 32'hdeadbeef;

  // ---------------- clock / reset ----------------
  logic gb_clk   = 1'b0;
  logic gb_rst_n = 1'b0;
  always #5 gb_clk = ~gb_clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [7:0]    cmd_len   = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_wen;
  logic          gb_rstb;
  logic [DW-1:0] gb_rdata;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] exp_q[$];

  gb_host_master #(.AW(AW), .DW(DW), .READ_DELAY(RD)) dut (
    .gb_clk    (gb_clk),
    .gb_rst_n  (gb_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .gb_addr   (gb_addr),
    .gb_wdata  (gb_wdata),
    .gb_wen    (gb_wen),
    .gb_rstb   (gb_rstb),
    .gb_rdata  (gb_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- slave model ----------------
  // Read data is valid only in cycle slave_delay after the strobe cycle;
  // every other cycle shows GARBAGE so a mistimed sample is visible.
  logic [7:0]    rstb_hist;
  logic [AW-1:0] strobe_addr;
  int            slave_delay = RD;
  logic [DW-1:0] slave_val   = 32'hd0;
  bit            addr_mode   = 1'b0;

  always @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      rstb_hist   <= '0;
      strobe_addr <= '0;
    end else begin
      rstb_hist <= {rstb_hist[6:0], gb_rstb};
      if (gb_rstb) strobe_addr <= gb_addr;
    end
  end

  always_comb begin
    gb_rdata = GARBAGE;
    if (rstb_hist[slave_delay-1])
      gb_rdata = addr_mode ? {8'hc0, strobe_addr} : slave_val;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge gb_clk);
    #1;
  endtask

  // Present a command and hold it until accepted; returns in the first
  // cycle after the accepting edge.
  task automatic do_cmd(input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [7:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_len   = len;
    while (!cmd_ready && n < 50) begin
      tick;
      n++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    tick;
    cmd_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    gb_rst_n  = 1'b0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 24'h000005;
    cmd_wdata = 32'h55;
    cmd_len   = 8'd0;
    repeat (3) tick;
    n_vec++;
    if ({cmd_ready, gb_wen, gb_rstb, rsp_valid, busy, rsp_write} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: {ready,wen,rstb,rvalid,busy,rwrite}=%b, required 000000",
               {cmd_ready, gb_wen, gb_rstb, rsp_valid, busy, rsp_write});
    end
    n_vec++;
    if ({gb_addr, gb_wdata, rsp_addr, rsp_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h wdata=%h raddr=%h rdata=%h, required all 0",
               gb_addr, gb_wdata, rsp_addr, rsp_rdata);
    end
    gb_rst_n = 1'b1;
    tick;
    n_vec++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_edge1: {ready,busy}=%b, required 10", {cmd_ready, busy});
    end
    tick;
    n_vec++;
    if ({busy, gb_wen, gb_addr} !== {2'b11, 24'h000005}) begin
      n_err++;
      $display("FAIL reset_edge2_accept: busy=%b wen=%b addr=%h, required 1 1 000005",
               busy, gb_wen, gb_addr);
    end
    cmd_valid = 1'b0;
    tick;
    tick;
    n_vec++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_drain: {busy,rvalid}=%b, required 00", {busy, rsp_valid});
    end
  endtask

  task automatic test_write;
    do_cmd(1'b1, 24'h000001, 32'h1, 8'd0);
    n_vec++;
    if ({gb_wen, gb_rstb, gb_addr, gb_wdata} !== {2'b10, 24'h000001, 32'h1}) begin
      n_err++;
      $display("FAIL write_strobe: wen=%b rstb=%b addr=%h wdata=%h, required 1 0 000001 00000001",
               gb_wen, gb_rstb, gb_addr, gb_wdata);
    end
    tick;
    n_vec++;
    if ({gb_wen, rsp_valid, rsp_write, rsp_addr, rsp_rdata} !== {3'b011, 24'h000001, 32'h0}) begin
      n_err++;
      $display("FAIL write_rsp: wen=%b rvalid=%b rwrite=%b raddr=%h rdata=%h, required 0 1 1 000001 0",
               gb_wen, rsp_valid, rsp_write, rsp_addr, rsp_rdata);
    end
    tick;
    n_vec++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL write_done: {rvalid,ready,busy}=%b, required 010 (3-cycle turnaround)",
               {rsp_valid, cmd_ready, busy});
    end
  endtask

  task automatic run_read(input string name, input logic [AW-1:0] a,
                          input int dly, input logic [DW-1:0] exp);
    int cyc = 0;
    bit addr_moved = 1'b0;
    slave_delay = dly;
    slave_val   = 32'hd0;
    addr_mode   = 1'b0;
    do_cmd(1'b0, a, 32'hffffffff, 8'd0);
    n_vec++;
    if ({gb_rstb, gb_wen, gb_wdata, gb_addr} !== {2'b10, 32'h0, a}) begin
      n_err++;
      $display("FAIL %s_strobe: rstb=%b wen=%b wdata=%h addr=%h, required 1 0 0 %h",
               name, gb_rstb, gb_wen, gb_wdata, gb_addr, a);
    end
    while (!rsp_valid && cyc < 40) begin
      tick;
      cyc++;
      if (gb_addr !== a || gb_rstb || gb_wen) addr_moved = 1'b1;
    end
    n_vec++;
    if (cyc != RD + 1 || addr_moved) begin
      n_err++;
      $display("FAIL %s_latency: rsp after %0d cycles addr_or_strobe_glitch=%b, required %0d cycles and 0",
               name, cyc, addr_moved, RD + 1);
    end
    n_vec++;
    if ({rsp_valid, rsp_write, rsp_addr, rsp_rdata} !== {2'b10, a, exp}) begin
      n_err++;
      $display("FAIL %s_data: rvalid=%b rwrite=%b raddr=%h rdata=%h, required 1 0 %h %h",
               name, rsp_valid, rsp_write, rsp_addr, rsp_rdata, a, exp);
    end
    tick;
    n_vec++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL %s_done: {rvalid,ready}=%b, required 01", name, {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read;
    run_read("read_exact", 24'h000020, 3, 32'hd0);
    run_read("read_early", 24'h000020, 2, GARBAGE);
    run_read("read_late",  24'h000020, 4, GARBAGE);
  endtask

  task automatic test_stall;
    int cyc = 0;
    rsp_ready   = 1'b0;
    slave_delay = RD;
    slave_val   = 32'h12345678;
    addr_mode   = 1'b0;
    do_cmd(1'b0, 24'h000abc, 32'h0, 8'd0);
    while (!rsp_valid && cyc < 40) begin
      tick;
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if ({rsp_valid, rsp_rdata, rsp_addr, cmd_ready} !== {1'b1, 32'h12345678, 24'h000abc, 1'b0}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: rvalid=%b rdata=%h raddr=%h ready=%b, required 1 12345678 000abc 0",
                 i, rsp_valid, rsp_rdata, rsp_addr, cmd_ready);
      end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    n_vec++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL stall_release: {rvalid,ready}=%b, required 01", {rsp_valid, cmd_ready});
    end
    do_cmd(1'b1, 24'h000077, 32'hcafe0001, 8'd0);
    n_vec++;
    if ({gb_wen, gb_addr, gb_wdata} !== {1'b1, 24'h000077, 32'hcafe0001}) begin
      n_err++;
      $display("FAIL stall_next_cmd: wen=%b addr=%h wdata=%h, required 1 000077 cafe0001",
               gb_wen, gb_addr, gb_wdata);
    end
    tick;
    tick;
  endtask

  task automatic test_reset_in_wait;
    bit seen = 1'b0;
    slave_delay = RD;
    do_cmd(1'b0, 24'h000040, 32'h0, 8'd0);
    tick;
    tick;
    gb_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, rsp_valid, gb_rstb, gb_wen, cmd_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_wait_abort: {busy,rvalid,rstb,wen,ready}=%b, required 00000",
               {busy, rsp_valid, gb_rstb, gb_wen, cmd_ready});
    end
    tick;
    tick;
    gb_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (rsp_valid || gb_rstb || gb_wen) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wait_quiet: stray rsp/strobe=%b, required 0", seen);
    end
    run_read("after_reset", 24'h000044, 3, 32'hd0);
  endtask

  task automatic test_burst;
    int cyc;
    int beat = 0;
    bit stray = 1'b0;
    logic [AW-1:0] e;
    rsp_ready   = 1'b1;
    slave_delay = RD;
    addr_mode   = 1'b1;
    exp_q.delete();
`ifdef GB_HOST_MASTER_BURST_EN
    exp_q.push_back(24'hfffffe);
    exp_q.push_back(24'hffffff);
    exp_q.push_back(24'h000000);
    exp_q.push_back(24'h000001);
`else
    exp_q.push_back(24'hfffffe);
`endif
    do_cmd(1'b0, 24'hfffffe, 32'h0, 8'd3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc = 0;
      while (!rsp_valid && cyc < 40) begin
        tick;
        cyc++;
      end
      n_vec++;
      if ({rsp_valid, rsp_write, rsp_addr, rsp_rdata} !== {2'b10, e, 8'hc0, e}) begin
        n_err++;
        $display("FAIL burst_beat%0d: rvalid=%b rwrite=%b raddr=%h rdata=%h, required 1 0 %h c0%h",
                 beat, rsp_valid, rsp_write, rsp_addr, rsp_rdata, e, e);
      end
      beat++;
      tick;
    end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || busy) stray = 1'b1;
      tick;
    end
    n_vec++;
    if (stray !== 1'b0) begin
      n_err++;
      $display("FAIL burst_extra: extra response or busy after last beat=%b, required 0", stray);
    end
    addr_mode = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_write;
    test_read;
    test_stall;
    test_reset_in_wait;
    test_burst;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gb_host_master.md
Name: gb_host_master

Overview:
- Upstream bus master that drives the ghostbus slave port (gb_addr/gb_wdata/gb_wen/gb_rstb/gb_rdata) of the generated top-level.
- Converts a valid/ready command stream (from a UART/Ethernet decoder or bench driver) into single-cycle ghostbus write and read strobes.
- Honours the fixed ghostbus read latency and returns one response per command on a valid/ready response stream.

Parameters:
AW, 24, ghostbus address width
DW, 32, ghostbus data width
READ_DELAY, 3, cycles from gb_rstb assertion to valid gb_rdata; must be >=1, elaboration error otherwise

Ports:
gb_clk  input  1  ghostbus clock; all logic on rising edge
gb_rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  AW  target address
cmd_wdata  input  DW  write data (ignored for reads)
cmd_len  input  8  burst beats minus one (used only with burst option)
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready
rsp_write  output  1  echo of cmd_write for this response
rsp_addr  output  AW  address of this beat
rsp_rdata  output  DW  captured read data; 0 for write acks
gb_addr  output  AW  ghostbus address
gb_wdata  output  DW  ghostbus write data
gb_wen  output  1  ghostbus write strobe
gb_rstb  output  1  ghostbus read strobe
gb_rdata  input  DW  ghostbus read data
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync deassert by gb_clk edge): state=IDLE; all outputs 0, including cmd_ready.
- A reset mid-transaction abandons it; no response is produced.
- cmd_ready = 1 only in IDLE; it is registered, rising the cycle after returning to IDLE.
- FSM states: IDLE, WRITE, READ, WAIT, RESP.
- IDLE: on accept, latch cmd_addr/cmd_wdata/cmd_write/cmd_len; next state WRITE if cmd_write, else READ.
- WRITE: gb_wen=1 for exactly one cycle, gb_addr/gb_wdata driven from the latch; next RESP with rsp_rdata=0.
- READ: gb_rstb=1 for exactly one cycle (call it cycle 0), gb_addr driven; next WAIT.
- WAIT: a down-counter of width clog2(READ_DELAY+1) runs. gb_rdata is sampled at the end of cycle READ_DELAY, then next state is RESP.
- gb_addr is held stable from cycle 0 through the sample cycle.
- gb_wen and gb_rstb are never high simultaneously and never high outside WRITE/READ.
- RESP: rsp_valid=1 with rsp_write/rsp_addr/rsp_rdata stable until rsp_ready. Response fields may change only after a handshake.
- Exit from RESP on handshake: to IDLE (or next beat, see option). rsp_ready held high gives zero stall.
- Throughput without stall: write = 3 cycles accept-to-accept; read = READ_DELAY+3 cycles.
- gb_wdata is zeroed on reads; gb_addr retains its last value in IDLE.

Optional Feature:
- Macro: GB_HOST_MASTER_BURST_EN.
- Defined: cmd_len=N issues N+1 beats of the same type.
  - Address increments by 1 per beat, wrapping modulo 2^AW.
  - Writes reuse cmd_wdata for every beat.
  - One response per beat; after each RESP handshake the FSM goes directly to WRITE/READ for the next beat until the beat counter reaches 0, then IDLE.
- Undefined: cmd_len is ignored (treated as 0); single-beat behaviour only.

Test Plan:
- Reset with cmd_valid=1 held -> cmd_ready=0, gb_wen=gb_rstb=0, all outputs 0; first accept on the 2nd edge after release.
- Write addr=24'h000001, data=32'h1 -> gb_wen pulses one cycle with gb_addr=24'h1, gb_wdata=32'h1; rsp_valid with rsp_write=1, rsp_rdata=0.
- Read addr=24'h000020, slave returns 32'hd0 exactly 3 cycles after gb_rstb -> rsp_rdata=32'hd0. Same read with data presented 1 cycle early/late -> mismatch captured.
- Read with rsp_ready=0 for 10 cycles -> rsp_valid/rsp_rdata held stable, cmd_ready=0 throughout; handshake then next command accepted.
- Reset asserted during WAIT -> no response; gb_rstb/gb_wen stay 0; next read completes normally.
- Burst (GB_HOST_MASTER_BURST_EN), read addr=24'hfffffe, len=3 -> reads at fffffe, ffffff, 000000, 000001 with 4 responses in order; without the macro -> single response.
